// File: rtl/complex_accum_dump.sv
// Integrate-and-dump of complex samples: sums N strobed di/dq samples per window.
// Latency: si/sq/output_strobe valid the cycle after the edge capturing the Nth sample.
// Backpressure: none; enable=0 freezes all state, and sync restarts the window.
//
// Ports:
//   clock, reset          rising-edge clock, async active-high reset
//   enable                clock enable; low holds every register including outputs
//   dump_len              window length minus one, sampled when a window starts
//   sync                  drop the partial sum and restart (strobed sample starts new window)
//   di, dq, input_strobe  signed complex sample and its valid
//   si, sq, output_strobe window sum and one-cycle strobe
//   busy                  high while a window is open (ACCUM)
module complex_accum_dump #(
  parameter int DWIDTH = 32,
  parameter int CWIDTH = 8
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [CWIDTH-1:0]               dump_len,
  input  logic                            sync,
  input  logic signed [DWIDTH-1:0]        di,
  input  logic signed [DWIDTH-1:0]        dq,
  input  logic                            input_strobe,
  output logic signed [DWIDTH+CWIDTH-1:0] si,
  output logic signed [DWIDTH+CWIDTH-1:0] sq,
  output logic                            output_strobe,
  output logic                            busy
);

  localparam int AW = DWIDTH + CWIDTH;
  localparam logic [CWIDTH:0] ONE = 1;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t              state;
  logic signed [AW-1:0] acc_i, acc_q;
  // count and n_lat need one extra bit: a full window holds 2^CWIDTH samples.
  logic [CWIDTH:0]      count;
  logic [CWIDTH:0]      n_lat;

  logic signed [AW-1:0] ext_i, ext_q;
  logic signed [AW-1:0] sum_i, sum_q;
  logic [CWIDTH:0]      count_inc;
  logic                 start;

  assign ext_i     = {{CWIDTH{di[DWIDTH-1]}}, di};
  assign ext_q     = {{CWIDTH{dq[DWIDTH-1]}}, dq};
  assign sum_i     = acc_i + ext_i;
  assign sum_q     = acc_q + ext_q;
  assign count_inc = count + ONE;
  // A strobed sample opens a new window from IDLE, or from any state when sync is high.
  assign start     = input_strobe && (sync || state == IDLE);
  assign busy      = (state == ACCUM);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      acc_i         <= '0;
      acc_q         <= '0;
      count         <= '0;
      n_lat         <= '0;
      si            <= '0;
      sq            <= '0;
      output_strobe <= 1'b0;
    end else if (enable) begin
      output_strobe <= 1'b0;
      if (start) begin
        n_lat <= {1'b0, dump_len} + ONE;
        if (dump_len == '0) begin
          // Single-sample window: the sample is the whole window, dump immediately.
          si            <= ext_i;
          sq            <= ext_q;
          output_strobe <= 1'b1;
          acc_i         <= '0;
          acc_q         <= '0;
          count         <= '0;
          state         <= IDLE;
        end else begin
          acc_i <= ext_i;
          acc_q <= ext_q;
          count <= ONE;
          state <= ACCUM;
        end
      end else if (sync) begin
        // Abandoned window never dumps.
        acc_i <= '0;
        acc_q <= '0;
        count <= '0;
        state <= IDLE;
      end else if (state == ACCUM && input_strobe) begin
        if (count_inc == n_lat) begin
          si            <= sum_i;
          sq            <= sum_q;
          output_strobe <= 1'b1;
          acc_i         <= '0;
          acc_q         <= '0;
          count         <= '0;
          state         <= IDLE;
        end else begin
          acc_i <= sum_i;
          acc_q <= sum_q;
          count <= count_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_complex_accum_dump.sv
// Directed bench for complex_accum_dump with hand-computed expected window sums.
// Inputs change 1 time unit after the rising edge; outputs are checked at that point too.
// Reset checks sample between edges to show the reset acts asynchronously.
module tb_complex_accum_dump;

  localparam int DW = 32;
  localparam int CW = 8;

  logic                        clock;
  logic                        reset;
  logic                        enable;
  logic [CW-1:0]               dump_len;
  logic                        sync;
  logic signed [DW-1:0]        di;
  logic signed [DW-1:0]        dq;
  logic                        input_strobe;
  logic signed [DW+CW-1:0]     si;
  logic signed [DW+CW-1:0]     sq;
  logic                        output_strobe;
  logic                        busy;

  int n_checks;
  int n_fail;

  complex_accum_dump #(.DWIDTH(DW), .CWIDTH(CW)) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .dump_len      (dump_len),
    .sync          (sync),
    .di            (di),
    .dq            (dq),
    .input_strobe  (input_strobe),
    .si            (si),
    .sq            (sq),
    .output_strobe (output_strobe),
    .busy          (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input longint observed, input longint expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Apply one cycle of inputs, then return 1 unit after the capturing edge.
  task automatic cyc(input logic stb, input logic signed [DW-1:0] i,
                     input logic signed [DW-1:0] q, input logic sy);
    input_strobe = stb;
    di           = i;
    dq           = q;
    sync         = sy;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, $urandom, $urandom, 1'b0);
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    reset        = 1'b0;
    enable       = 1'b1;
    dump_len     = 8'd3;
    sync         = 1'b0;
    input_strobe = 1'b0;
    di           = '0;
    dq           = '0;

    // Async reset between edges with random inputs.
    for (int k = 0; k < 3; k++) cyc($urandom_range(0, 1), $urandom, $urandom, 1'b0);
    #3 reset = 1'b1;
    #1;
    check("rst_si", si, 0);
    check("rst_sq", sq, 0);
    check("rst_ostb", output_strobe, 0);
    check("rst_busy", busy, 0);
    for (int k = 0; k < 2; k++) cyc($urandom_range(0, 1), $urandom, $urandom, $urandom_range(0, 1));
    #2 reset = 1'b0;
    idle();
    check("rst_hold_ostb", output_strobe, 0);

    // Basic 4-sample window.
    dump_len = 8'd3;
    cyc(1'b1, 1, -1, 1'b0);
    check("w4_busy1", busy, 1);
    check("w4_ostb1", output_strobe, 0);
    cyc(1'b1, 2, -2, 1'b0);
    cyc(1'b1, 3, -3, 1'b0);
    check("w4_ostb3", output_strobe, 0);
    cyc(1'b1, 4, -4, 1'b0);
    check("w4_ostb", output_strobe, 1);
    check("w4_si", si, 10);
    check("w4_sq", sq, -10);
    check("w4_busy", busy, 0);
    idle();
    check("w4_ostb_off", output_strobe, 0);
    check("w4_si_hold", si, 10);

    // N==1: every strobe is its own window.
    dump_len = 8'd0;
    cyc(1'b1, 5, 9, 1'b0);
    check("n1_ostb_a", output_strobe, 1);
    check("n1_si_a", si, 5);
    check("n1_sq_a", sq, 9);
    check("n1_busy_a", busy, 0);
    cyc(1'b1, -7, 0, 1'b0);
    check("n1_ostb_b", output_strobe, 1);
    check("n1_si_b", si, -7);
    check("n1_busy_b", busy, 0);
    idle();
    check("n1_ostb_off", output_strobe, 0);

    // sync with a strobed sample restarts; abandoned partial (10) never dumps.
    dump_len = 8'd3;
    cyc(1'b1, 5, -5, 1'b0);
    cyc(1'b1, 5, -5, 1'b0);
    cyc(1'b1, 7, -7, 1'b1);
    check("sync_ostb", output_strobe, 0);
    check("sync_busy", busy, 1);
    cyc(1'b1, 7, -7, 1'b0);
    cyc(1'b1, 7, -7, 1'b0);
    check("sync_ostb3", output_strobe, 0);
    cyc(1'b1, 7, -7, 1'b0);
    check("sync_dump_ostb", output_strobe, 1);
    check("sync_dump_si", si, 28);
    check("sync_dump_sq", sq, -28);
    // sync without strobe returns to IDLE, no dump.
    cyc(1'b1, 1, 1, 1'b0);
    check("sync_idle_pre", busy, 1);
    cyc(1'b0, 0, 0, 1'b1);
    check("sync_idle_busy", busy, 0);
    check("sync_idle_ostb", output_strobe, 0);
    check("sync_idle_si", si, 28);

    // Gaps, enable low mid-window (strobes ignored), dump_len change mid-window.
    dump_len = 8'd3;
    cyc(1'b1, 1, 10, 1'b0);
    dump_len = 8'd0;
    idle();
    cyc(1'b1, 2, 20, 1'b0);
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 100, 100, 1'b0);
      check("en_lo_busy", busy, 1);
    end
    enable = 1'b1;
    cyc(1'b1, 3, 30, 1'b0);
    check("gap_ostb3", output_strobe, 0);
    idle();
    cyc(1'b1, 4, 40, 1'b0);
    check("gap_ostb", output_strobe, 1);
    check("gap_si", si, 10);
    check("gap_sq", sq, 100);
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 55, 55, 1'b1);
      check("en_lo_ostb_held", output_strobe, 1);
    end
    check("en_lo_si_held", si, 10);
    enable = 1'b1;
    idle();
    check("gap_ostb_off", output_strobe, 0);
    check("gap_busy", busy, 0);

    // Full 256-sample window at extreme values: no wrap.
    dump_len = 8'd255;
    for (int k = 0; k < 256; k++) begin
      cyc(1'b1, 32'sh8000_0000, 32'sh7fff_ffff, 1'b0);
      if (k == 254) begin
        check("big_ostb255", output_strobe, 0);
        check("big_busy255", busy, 1);
      end
    end
    check("big_ostb", output_strobe, 1);
    check("big_si", si, -64'sd549755813888);
    check("big_sq", sq, 64'sd549755813632);
    check("big_busy", busy, 0);

    // Reset mid-window: partial discarded, outputs cleared between edges.
    for (int k = 0; k < 100; k++) cyc(1'b1, 1, 1, 1'b0);
    check("mid_busy", busy, 1);
    #3 reset = 1'b1;
    #1;
    check("mid_rst_si", si, 0);
    check("mid_rst_sq", sq, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ostb", output_strobe, 0);
    #2 reset = 1'b0;
    idle();
    idle();
    check("post_rst_ostb", output_strobe, 0);
    dump_len = 8'd1;
    cyc(1'b1, 3, -3, 1'b0);
    cyc(1'b1, 4, -4, 1'b0);
    check("post_rst_ostb2", output_strobe, 1);
    check("post_rst_si", si, 7);
    check("post_rst_sq", sq, -7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Backstop so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
